itype_issue_unit: RTL and testbench

Multi-cycle issue/writeback sequencer that drives the `aluModul` operand interface (`OPCode`, `Rs`, `Rt`, `Immediate`) from a stream of 32-bit MIPS I-type instructions and consumes its `Result`, `Zero` and `overFlow` outputs. It owns a 32x32 register file, extends immediates, and issues load/store memory requests. It retires branch decisions. It sits between instruction fetch and the ALU, one instruction in flight at a time.

---
 rtl/itype_pkg.sv | 43 ++++
 rtl/regfile_32x32.sv | 32 +++
 rtl/itype_issue_unit.sv | 164 ++++++++++++++++
 tb/tb_itype_issue_unit.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/itype_pkg.sv
// Shared definitions for the I-type issue unit:
// opcodes, sequencer states and immediate helpers.
package itype_pkg;

    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    // Logical immediates zero-extend; LUI hands the raw imm to the ALU.
    function automatic logic [31:0] ext_imm(input logic [5:0] op,
                                            input logic [15:0] imm);
        if (op == OP_ANDI || op == OP_ORI || op == OP_LUI)
            return {16'h0000, imm};
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
                          OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW};
    endfunction

    function automatic logic writes_rt(input logic [5:0] op);
        return op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                          OP_ANDI, OP_ORI, OP_LUI, OP_LW};
    endfunction

endpackage

// File: rtl/regfile_32x32.sv
// 32x32 register file: two operand reads, one debug read,
// one synchronous write; r0 is hardwired to zero.
module regfile_32x32 (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    input  logic [4:0]  i_dbg_raddr,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2,
    output logic [31:0] o_dbg_rdata,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata
);

    logic [31:0] r_regs [32];

    // Clear everything on reset, otherwise accept one write per cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (i_we && i_waddr != 5'd0) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rd1       = (i_ra1 == 5'd0) ? 32'd0 : r_regs[i_ra1];
    assign o_rd2       = (i_ra2 == 5'd0) ? 32'd0 : r_regs[i_ra2];
    assign o_dbg_rdata = (i_dbg_raddr == 5'd0) ? 32'd0 : r_regs[i_dbg_raddr];

endmodule

// File: rtl/itype_issue_unit.sv
// Multi-cycle I-type sequencer: decode, drive ALU operands,
// optional memory access, then writeback and retirement pulses.
module itype_issue_unit
    import itype_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_instr_valid,
    output logic        o_instr_ready,
    input  logic [31:0] i_instr,
    output logic [5:0]  o_alu_opcode,
    output logic [31:0] o_alu_rs,
    output logic [31:0] o_alu_rt,
    output logic [31:0] o_alu_immediate,
    input  logic [31:0] i_alu_result,
    input  logic        i_alu_zero,
    input  logic        i_alu_overflow,
    input  logic        i_alu_carryout,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_branch_valid,
    output logic        o_branch_taken,
    output logic [31:0] o_branch_offset,
    output logic        o_done,
    output logic        o_exc_overflow,
    output logic        o_exc_illegal,
    input  logic [4:0]  i_dbg_raddr,
    output logic [31:0] o_dbg_rdata
);

    state_t      r_state;
    logic [31:0] r_instr;
    logic [31:0] r_result;
    logic        r_ovf;
    logic [31:0] r_load;

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [31:0] w_ext;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic        w_we;
    logic [31:0] w_wdata;
    logic        w_unused;

    assign w_op  = r_instr[31:26];
    assign w_rs  = r_instr[25:21];
    assign w_rt  = r_instr[20:16];
    assign w_ext = ext_imm(w_op, r_instr[15:0]);

    // Carry-out has no architectural meaning for these opcodes.
    assign w_unused = i_alu_carryout;

    assign w_we = (r_state == S_WB) && writes_rt(w_op)
                  && !(w_op == OP_ADDI && r_ovf);
    assign w_wdata = (w_op == OP_LW) ? r_load : r_result;

    regfile_32x32 u_regs (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_ra1       (w_rs),
        .i_ra2       (w_rt),
        .i_dbg_raddr (i_dbg_raddr),
        .o_rd1       (w_rs_val),
        .o_rd2       (w_rt_val),
        .o_dbg_rdata (o_dbg_rdata),
        .i_we        (w_we),
        .i_waddr     (w_rt),
        .i_wdata     (w_wdata)
    );

    // Sequencer; retirement pulses are set on entry to WB and cleared after.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= S_IDLE;
            r_instr         <= '0;
            r_result        <= '0;
            r_ovf           <= 1'b0;
            r_load          <= '0;
            o_instr_ready   <= 1'b1;
            o_alu_opcode    <= '0;
            o_alu_rs        <= '0;
            o_alu_rt        <= '0;
            o_alu_immediate <= '0;
            o_mem_req       <= 1'b0;
            o_mem_we        <= 1'b0;
            o_mem_addr      <= '0;
            o_mem_wdata     <= '0;
            o_branch_valid  <= 1'b0;
            o_branch_taken  <= 1'b0;
            o_branch_offset <= '0;
            o_done          <= 1'b0;
            o_exc_overflow  <= 1'b0;
            o_exc_illegal   <= 1'b0;
        end else begin
            o_done         <= 1'b0;
            o_exc_overflow <= 1'b0;
            o_exc_illegal  <= 1'b0;
            o_branch_valid <= 1'b0;
            o_branch_taken <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_instr_valid) begin
                        r_instr       <= i_instr;
                        o_instr_ready <= 1'b0;
                        r_state       <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    o_alu_opcode    <= w_op;
                    o_alu_rs        <= w_rs_val;
                    o_alu_rt        <= w_rt_val;
                    o_alu_immediate <= w_ext;
                    r_state         <= S_EXEC;
                end
                S_EXEC: begin
                    r_result <= i_alu_result;
                    r_ovf    <= i_alu_overflow;
                    if (!is_legal(w_op)) begin
                        o_exc_illegal <= 1'b1;
                        o_done        <= 1'b1;
                        r_state       <= S_WB;
                    end else if (w_op == OP_LW || w_op == OP_SW) begin
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= (w_op == OP_SW);
                        o_mem_addr  <= i_alu_result;
                        o_mem_wdata <= o_alu_rt;
                        r_state     <= S_MEM;
                    end else begin
                        o_done         <= 1'b1;
                        o_exc_overflow <= (w_op == OP_ADDI) && i_alu_overflow;
                        if (w_op == OP_BEQ || w_op == OP_BNE) begin
                            o_branch_valid  <= 1'b1;
                            o_branch_taken  <= (w_op == OP_BEQ) ? i_alu_zero
                                                                : !i_alu_zero;
                            o_branch_offset <= {w_ext[29:0], 2'b00};
                        end
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (i_mem_ack) begin
                        o_mem_req <= 1'b0;
                        o_mem_we  <= 1'b0;
                        r_load    <= i_mem_rdata;
                        o_done    <= 1'b1;
                        r_state   <= S_WB;
                    end
                end
                S_WB: begin
                    o_instr_ready <= 1'b1;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_itype_issue_unit.sv
// Scoreboard bench for itype_issue_unit with a behavioural ALU,
// memory responder and architectural register model.
module tb_itype_issue_unit;

    localparam logic [5:0] BEQ = 6'h04, BNE = 6'h05, ADDI = 6'h08;
    localparam logic [5:0] ADDIU = 6'h09, SLTI = 6'h0A, SLTIU = 6'h0B;
    localparam logic [5:0] ANDI = 6'h0C, ORI = 6'h0D, LUI = 6'h0F;
    localparam logic [5:0] LW = 6'h23, SW = 6'h2B, BAD = 6'h3F;

    typedef struct packed {
        logic ill; logic ovf; logic bv; logic bt; logic [31:0] off;
    } exp_t;
    typedef struct packed {
        logic we; logic [31:0] addr; logic [31:0] wdata;
    } mem_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid, instr_ready;
    logic [31:0] instr;
    logic [5:0]  alu_opcode;
    logic [31:0] alu_rs, alu_rt, alu_imm, alu_result;
    logic        alu_zero, alu_ovf;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        br_valid, br_taken;
    logic [31:0] br_off;
    logic        done, exc_ovf, exc_ill;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] R [32];
    exp_t exp_q[$];
    mem_t mem_q[$];
    exp_t e_mon;
    mem_t m_cur;
    logic prev_req = 1'b0;
    logic [5:0] ops [12];

    always #5 clk = ~clk;

    itype_issue_unit dut (
        .i_clk(clk), .i_reset(reset),
        .i_instr_valid(instr_valid), .o_instr_ready(instr_ready),
        .i_instr(instr),
        .o_alu_opcode(alu_opcode), .o_alu_rs(alu_rs), .o_alu_rt(alu_rt),
        .o_alu_immediate(alu_imm),
        .i_alu_result(alu_result), .i_alu_zero(alu_zero),
        .i_alu_overflow(alu_ovf), .i_alu_carryout(1'b0),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_ack(mem_ack),
        .i_mem_rdata(mem_rdata),
        .o_branch_valid(br_valid), .o_branch_taken(br_taken),
        .o_branch_offset(br_off),
        .o_done(done), .o_exc_overflow(exc_ovf), .o_exc_illegal(exc_ill),
        .i_dbg_raddr(dbg_raddr), .o_dbg_rdata(dbg_rdata)
    );

    // Reference ALU driven purely by the DUT's operand outputs.
    always_comb begin
        logic [31:0] s;
        s = alu_rs + alu_imm;
        alu_result = 32'd0;
        alu_ovf = 1'b0;
        case (alu_opcode)
            ADDI, ADDIU, LW, SW: begin
                alu_result = s;
                alu_ovf = (alu_rs[31] == alu_imm[31]) && (s[31] != alu_rs[31]);
            end
            SLTI:     alu_result = {31'd0, $signed(alu_rs) < $signed(alu_imm)};
            SLTIU:    alu_result = {31'd0, alu_rs < alu_imm};
            ANDI:     alu_result = alu_rs & alu_imm;
            ORI:      alu_result = alu_rs | alu_imm;
            LUI:      alu_result = alu_imm << 16;
            BEQ, BNE: alu_result = alu_rs - alu_rt;
            default:  alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input int rs,
                                       input int rt, input logic [15:0] imm);
        logic [4:0] a, b;
        a = rs[4:0];
        b = rt[4:0];
        return {op, a, b, imm};
    endfunction

    // Monitor: retirement pulses and memory requests against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL done_unexpected: got 1 expected 0");
                end else begin
                    e_mon = exp_q.pop_front();
                    check("exc_illegal", {31'd0, exc_ill}, {31'd0, e_mon.ill});
                    check("exc_overflow", {31'd0, exc_ovf}, {31'd0, e_mon.ovf});
                    check("branch_valid", {31'd0, br_valid}, {31'd0, e_mon.bv});
                    if (e_mon.bv) begin
                        check("branch_taken", {31'd0, br_taken},
                              {31'd0, e_mon.bt});
                        check("branch_offset", br_off, e_mon.off);
                    end
                end
            end else begin
                check("no_stray_pulse", {29'd0, exc_ill, exc_ovf, br_valid},
                      32'd0);
            end
            if (mem_req && !prev_req) begin
                if (mem_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL mem_unexpected: got 1 expected 0");
                end else begin
                    m_cur = mem_q.pop_front();
                end
            end
            if (mem_req) begin
                check("mem_we", {31'd0, mem_we}, {31'd0, m_cur.we});
                check("mem_addr", mem_addr, m_cur.addr);
                check("mem_wdata", mem_wdata, m_cur.wdata);
            end
            prev_req = mem_req;
        end else begin
            prev_req = 1'b0;
        end
    end

    // Model one instruction, then drive it with a k-cycle ack delay.
    task automatic run(input logic [31:0] ins, input int k,
                       input logic [31:0] rd);
        logic [5:0]  op;
        logic [4:0]  rs, rt;
        logic [31:0] a, b, se, ze, xi, res, wv;
        logic        wr;
        exp_t        e;
        mem_t        m;
        int          lat, cyc, rc, n;
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
        a = R[rs]; b = R[rt];
        se = {{16{ins[15]}}, ins[15:0]};
        ze = {16'd0, ins[15:0]};
        xi = (op == ANDI || op == ORI || op == LUI) ? ze : se;
        e = '0; lat = 4; wr = 1'b0; wv = 32'd0;
        case (op)
            ADDI: begin
                res = a + se;
                e.ovf = ($signed(a) + $signed(se)) != $signed(res) ||
                        (a[31] == se[31] && res[31] != a[31]);
                wr = !e.ovf; wv = res;
            end
            ADDIU: begin wr = 1; wv = a + se; end
            SLTI:  begin wr = 1; wv = ($signed(a) < $signed(se)) ? 1 : 0; end
            SLTIU: begin wr = 1; wv = (a < se) ? 1 : 0; end
            ANDI:  begin wr = 1; wv = a & ze; end
            ORI:   begin wr = 1; wv = a | ze; end
            LUI:   begin wr = 1; wv = ze * 65536; end
            BEQ, BNE: begin
                e.bv = 1; e.bt = (op == BEQ) ? (a == b) : (a != b);
                e.off = se * 4;
            end
            LW: begin
                wr = 1; wv = rd; lat = 5 + k;
                m.we = 0; m.addr = a + se; m.wdata = b; mem_q.push_back(m);
            end
            SW: begin
                lat = 5 + k;
                m.we = 1; m.addr = a + se; m.wdata = b; mem_q.push_back(m);
            end
            default: e.ill = 1;
        endcase
        exp_q.push_back(e);
        if (wr && rt != 0) R[rt] = wv;

        @(negedge clk);
        n = 0;
        while (!instr_ready && n < 50) begin @(negedge clk); n++; end
        instr = ins; instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        rc = 0;
        for (cyc = 1; cyc < 60; cyc++) begin
            @(negedge clk);
            if (instr_ready) break;
            if (cyc == 2) begin
                check("alu_opcode", {26'd0, alu_opcode}, {26'd0, op});
                check("alu_rs", alu_rs, a);
                check("alu_rt", alu_rt, b);
                check("alu_immediate", alu_imm, xi);
            end
            if (cyc == lat - 1) check("done_cycle", {31'd0, done}, 32'd1);
            if (mem_req) begin
                mem_ack = (rc == k); rc++;
            end else begin
                mem_ack = 1'($urandom % 2);
            end
            mem_rdata = mem_ack ? rd : $urandom;
            instr_valid = 1'($urandom % 2);
            instr = $urandom;
        end
        instr_valid = 1'b0; mem_ack = 1'b0;
        check("latency", cyc, lat);
        dbg_raddr = rt;
        #1 check("reg_rt", dbg_rdata, R[rt]);
    endtask

    // Abort a store stuck in MEM with reset.
    task automatic reset_mid();
        int n;
        mem_t m;
        m.we = 1; m.addr = R[9] + 3; m.wdata = R[8]; mem_q.push_back(m);
        @(negedge clk);
        instr = mk(SW, 9, 8, 16'd3); instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        n = 0;
        while (n < 2) begin
            @(negedge clk);
            if (mem_req) n++;
        end
        reset = 1'b1;
        @(negedge clk);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_ready", {31'd0, instr_ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) R[i] = 32'd0;
        for (int i = 1; i < 32; i++) begin
            dbg_raddr = 5'(i);
            #1 check("rst_reg", dbg_rdata, 32'd0);
        end
    endtask

    task automatic rand_run(input int cnt);
        logic [5:0] op;
        for (int i = 0; i < cnt; i++) begin
            op = ops[$urandom_range(0, 11)];
            run(mk(op, $urandom_range(0, 7), $urandom_range(0, 7),
                   16'($urandom)), $urandom_range(0, 3), $urandom);
        end
    endtask

    initial begin
        ops = '{ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, LUI, BEQ, BNE, LW, SW, BAD};
        for (int i = 0; i < 32; i++) R[i] = 32'd0;
        reset = 1'b1; instr_valid = 1'b0; instr = '0;
        mem_ack = 1'b0; mem_rdata = '0; dbg_raddr = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_ready", {31'd0, instr_ready}, 32'd1);
        check("reset_outs", {26'd0, done, mem_req, mem_we, br_valid,
              exc_ovf, exc_ill}, 32'd0);
        check("reset_alu_imm", alu_imm, 32'd0);

        run(32'h2001B4E9, 0, 0);
        run(mk(LUI, 0, 2, 16'h7FFF), 0, 0);
        run(mk(ORI, 2, 2, 16'hFFFF), 0, 0);
        run(mk(ADDI, 2, 3, 16'd1), 0, 0);
        run(mk(ADDIU, 2, 3, 16'd1), 0, 0);
        run(mk(ORI, 0, 5, 16'h2B3C), 0, 0);
        run(mk(ANDI, 5, 4, 16'hFFFF), 0, 0);
        run(mk(ORI, 0, 4, 16'h8000), 0, 0);
        run(mk(ADDIU, 0, 6, 16'd5), 0, 0);
        run(mk(ADDIU, 0, 7, 16'd5), 0, 0);
        run(mk(BEQ, 6, 7, 16'hFFFE), 0, 0);
        run(mk(BNE, 6, 7, 16'hFFFE), 0, 0);
        run(mk(ADDIU, 0, 9, 16'd14), 0, 0);
        run(mk(LUI, 0, 8, 16'h000F), 0, 0);
        run(mk(ORI, 8, 8, 16'hF4F3), 0, 0);
        run(mk(SW, 9, 8, 16'd3), 3, 0);
        run(mk(LW, 9, 10, 16'd3), 0, 32'hCAFEF00D);
        run(mk(BAD, 1, 2, 16'h1234), 0, 0);
        run(mk(ADDI, 0, 1, 16'h0000), 0, 0);

        rand_run(40);
        reset_mid();
        rand_run(10);

        for (int i = 0; i < 32; i++) begin
            dbg_raddr = 5'(i);
            #1 check("final_reg", dbg_rdata, R[i]);
        end
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
